salu_fetch_issue: RTL

- Scalar instruction front end, directly upstream of the scalar ALU.
- Fetches 32-bit dwords from instruction memory at a byte PC and buffers them in a small FIFO.
- Classifies each instruction by encoding (SOP1/SOP2/SOPK/SOPC/SOPP) and attaches a trailing 32-bit literal when a source operand selects it.
- Issues one complete instruction per cycle to the scalar ALU over a valid/ready handshake, and honours PC redirects from the ALU's program-counter logic by flushing.

---
 rtl/salu_pkg.sv | 47 ++++
 rtl/salu_fetch_issue_if.sv | 35 +++
 rtl/salu_dword_fifo.sv | 68 ++++++
 rtl/salu_fetch_issue.sv | 103 ++++++++++
 4 files changed

// File: rtl/salu_pkg.sv
// Shared encodings, class codes and decode helpers for the scalar fetch/issue front end.
package salu_pkg;

  localparam logic [8:0] ENC_SOP1    = 9'h17D;
  localparam logic [8:0] ENC_SOPC    = 9'h17E;
  localparam logic [8:0] ENC_SOPP    = 9'h17F;
  localparam logic [3:0] ENC_SOPK    = 4'hB;
  localparam logic [1:0] ENC_SOP2    = 2'b10;
  localparam logic [7:0] LITERAL_SEL = 8'hFF;

  typedef enum logic [2:0] {
    CLS_SOP2  = 3'd0,
    CLS_SOP1  = 3'd1,
    CLS_SOPK  = 3'd2,
    CLS_SOPC  = 3'd3,
    CLS_SOPP  = 3'd4,
    CLS_OTHER = 3'd7
  } inst_class_e;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } fe_state_e;

  // The 9-bit encodings overlap the SOPK nibble, so they must be tested first.
  function automatic inst_class_e classify(input logic [31:0] d);
    inst_class_e c;
    if (d[31:23] == ENC_SOP1)      c = CLS_SOP1;
    else if (d[31:23] == ENC_SOPC) c = CLS_SOPC;
    else if (d[31:23] == ENC_SOPP) c = CLS_SOPP;
    else if (d[31:28] == ENC_SOPK) c = CLS_SOPK;
    else if (d[31:30] == ENC_SOP2) c = CLS_SOP2;
    else                           c = CLS_OTHER;
    return c;
  endfunction

  function automatic logic needs_literal(input inst_class_e c, input logic [31:0] d);
    logic lit;
    case (c)
      CLS_SOP2, CLS_SOPC: lit = (d[7:0] == LITERAL_SEL) || (d[15:8] == LITERAL_SEL);
      CLS_SOP1:           lit = (d[7:0] == LITERAL_SEL);
      default:            lit = 1'b0;
    endcase
    return lit;
  endfunction

endpackage

// File: rtl/salu_fetch_issue_if.sv
// Instruction-memory, redirect and issue signals of the scalar front end.
interface salu_fetch_issue_if #(
  parameter int unsigned PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            issue_valid;
  logic            issue_ready;
  logic [31:0]     issue_inst;
  logic [31:0]     issue_literal;
  logic            issue_has_lit;
  logic [2:0]      issue_class;
  logic [PC_W-1:0] issue_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output issue_valid, issue_inst, issue_literal, issue_has_lit, issue_class, issue_pc,
    input  issue_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  issue_valid, issue_inst, issue_literal, issue_has_lit, issue_class, issue_pc,
    output issue_ready
  );
endinterface

// File: rtl/salu_dword_fifo.sv
// Dword FIFO tagged with the fetch PC; pops one or two entries, flush clears it.
module salu_dword_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            push,
  input  logic [31:0]     push_data,
  input  logic [PC_W-1:0] push_pc,
  input  logic            pop,
  input  logic            pop_two,
  output logic [31:0]     head_data,
  output logic [PC_W-1:0] head_pc,
  output logic [31:0]     next_data,
  output logic [CW-1:0]   count
);

  logic [31:0]     data_q [DEPTH];
  logic [PC_W-1:0] pc_q   [DEPTH];
  logic [AW-1:0]   rd_q, wr_q, rd_step;
  logic [CW-1:0]   cnt_q, cnt_dec;

  always_comb begin
    rd_step = '0;
    cnt_dec = '0;
    if (pop_two) begin
      rd_step = AW'(2);
      cnt_dec = CW'(2);
    end else if (pop) begin
      rd_step = AW'(1);
      cnt_dec = CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      rd_q  <= rd_q + rd_step;
      cnt_q <= cnt_q + CW'(push) - cnt_dec;
    end
  end

  // Storage needs no reset: every read of it is qualified by count.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      data_q[wr_q] <= push_data;
      pc_q[wr_q]   <= push_pc;
    end
  end

  assign head_data = data_q[rd_q];
  assign head_pc   = pc_q[rd_q];
  assign next_data = data_q[rd_q + AW'(1)];
  assign count     = cnt_q;

endmodule

// File: rtl/salu_fetch_issue.sv
// Scalar front end: credit-limited dword fetch, decode/literal pairing, issue to the SALU.
module salu_fetch_issue
  import salu_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 4
) (
  input logic               clock,
  input logic               reset_n,
  salu_fetch_issue_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);

  fe_state_e       state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, resp_pc_q, redirect_al;
  logic [OW-1:0]   out_q, out_d;
  logic            credit_ok, gnt_fire, resp_fire, push, xfer;
  logic [31:0]     head_data, next_data;
  logic [PC_W-1:0] head_pc;
  logic [CW-1:0]   fifo_count;
  inst_class_e     head_cls;
  logic            head_lit, issue_valid;

  assign redirect_al = bus.redirect_pc & ~PC_W'(3);
  assign credit_ok   = ((32'(out_q) + 32'(fifo_count)) < DEPTH) && (32'(out_q) < MAX_OUT);

  assign bus.imem_req  = (state_q == ST_FETCH) && reset_n && credit_ok;
  assign bus.imem_addr = fetch_pc_q;

  // Responses with nothing outstanding are stale (issued before a reset) and are dropped.
  assign gnt_fire  = bus.imem_req && bus.imem_gnt;
  assign resp_fire = bus.imem_rvalid && (out_q != '0);
  assign push      = resp_fire && (state_q == ST_FETCH) && !bus.redirect_valid;
  assign out_d     = out_q + OW'(gnt_fire) - OW'(resp_fire);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_FETCH;
    else          state_q <= state_d;
  end

  // A grant on the redirect edge is counted, so its response is drained like the rest.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: state_d = ST_FETCH;
      ST_DRAIN: if (out_d == '0) state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
    if (bus.redirect_valid) state_d = (out_d == '0) ? ST_FETCH : ST_DRAIN;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= '0;
      resp_pc_q  <= '0;
      out_q      <= '0;
    end else begin
      out_q <= out_d;
      if (bus.redirect_valid) begin
        fetch_pc_q <= redirect_al;
        resp_pc_q  <= redirect_al;
      end else begin
        if (gnt_fire) fetch_pc_q <= fetch_pc_q + PC_W'(4);
        if (push)     resp_pc_q  <= resp_pc_q + PC_W'(4);
      end
    end
  end

  assign xfer = issue_valid && bus.issue_ready && !bus.redirect_valid;

  salu_dword_fifo #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (bus.imem_rdata),
    .push_pc   (resp_pc_q),
    .pop       (xfer && !head_lit),
    .pop_two   (xfer && head_lit),
    .head_data (head_data),
    .head_pc   (head_pc),
    .next_data (next_data),
    .count     (fifo_count)
  );

  assign head_cls    = classify(head_data);
  assign head_lit    = needs_literal(head_cls, head_data);
  assign issue_valid = (fifo_count != '0) && (!head_lit || (fifo_count >= CW'(2)));

  assign bus.issue_valid   = issue_valid;
  assign bus.issue_inst    = issue_valid ? head_data : '0;
  assign bus.issue_pc      = issue_valid ? head_pc : '0;
  assign bus.issue_class   = issue_valid ? head_cls : 3'd0;
  assign bus.issue_has_lit = issue_valid && head_lit;
  assign bus.issue_literal = (issue_valid && head_lit) ? next_data : '0;

endmodule
